alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: requester holding round-robin priority after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts that requester's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8  operands.
REQ-007 req0_op / req1_op  input  3  opcode.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_data  output  8  result.
REQ-011 rsp_id  output  1  index of requester that issued the result.
REQ-012 rsp_zero  output  1  result-equals-zero flag, present only under ALU_ARB_ZFLAG_EN.

Function
REQ-013 FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid && rsp_ready.
REQ-014 Grant in IDLE: one valid requester wins; both valid wins the priority holder; none valid means no grant.
REQ-015 reqN_ready SHALL be 1 only in IDLE for the granted requester; it may depend combinationally on reqN_valid; at most one ready per cycle.
REQ-016 Accept occurs on reqN_valid && reqN_ready; operands, opcode and id are registered that cycle.
REQ-017 Requesters SHALL hold valid and payload stable until accepted; the arbiter does not accept in EXEC or RESP.
REQ-018 Opcodes: 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 ~a, 101-111 a+b; all arithmetic mod 256, carry/borrow discarded.
REQ-019 EXEC computes from registered operands and registers rsp_data and rsp_id; rsp_valid rises entering RESP.
REQ-020 Latency: accept at cycle N gives rsp_valid=1 at cycle N+2; minimum issue interval 3 cycles.
REQ-021 In RESP, rsp_valid, rsp_data, rsp_id and rsp_zero SHALL hold stable until rsp_ready=1.
REQ-022 On response handshake, priority passes to the requester not just served.
REQ-023 rsp_valid is 0 in IDLE and EXEC.

Reset
REQ-024 With rst_n=0 at a clock edge: state=IDLE, priority=RR_INIT, rsp_valid=0, rsp_data=0x00, rsp_id=0, rsp_zero=0, both ready=0.
REQ-025 Reset in EXEC or RESP abandons the operation; no response is issued for it.

Configuration
REQ-026 Macro ALU_ARB_ZFLAG_EN defined: rsp_zero port exists, registered with rsp_data, equals 1 iff the result is 0x00.
REQ-027 Macro ALU_ARB_ZFLAG_EN undefined: rsp_zero port and its register are absent; all other behaviour is identical.

Structure
REQ-028 Package alu_pkg holds the opcode constants (ADD, SUB, AND, OR, NOT) and the FSM state typedef.
REQ-029 The datapath is sub-module alu_core: combinational, 8-bit a/b, 3-bit op, implementing REQ-018, instantiated once.
REQ-030 alu_arbiter contains the FSM, grant logic, priority register and operand/result registers.

Verification
REQ-031 Only req0 valid, a=0x05 b=0x03 op=000 at cycle N -> req0_ready=1 at N; rsp_valid=1 at N+2 with rsp_data=0x08 and rsp_id=0.
REQ-032 Both valid after reset (RR_INIT=0): req0 a=0x10 b=0x20 op=001; req1 a=0xF0 b=0x3C op=010 -> first rsp 0xF0 id0, then rsp 0x30 id1.
REQ-033 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant; no ready asserted; completes on the cycle rsp_ready=1.
REQ-034 Opcodes 100 with a=0x5A, and 110 with a=0x01 b=0xFF -> rsp_data 0xA5, then 0x00 (wrap-around).
REQ-035 rst_n=0 during EXEC -> next cycle rsp_valid=0, state IDLE, no stale response; a following request completes normally.
REQ-036 ALU_ARB_ZFLAG_EN defined, a=0x01 b=0x01 op=001 -> rsp_data=0x00, rsp_zero=1; a=0x02 b=0x01 -> rsp_zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state type shared by the ALU arbiter files
package alu_pkg;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] NOT = 3'b100;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two request channels and one response channel; ALU_ARB_ZFLAG_EN adds rsp_zero
interface alu_arbiter_if;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
`ifdef ALU_ARB_ZFLAG_EN
  logic       rsp_zero;
`endif
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ARB_ZFLAG_EN
    , input rsp_zero
`endif
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ARB_ZFLAG_EN
    , output rsp_zero
`endif
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational 8-bit ALU; unused opcodes fall back to add
module alu_core
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] y
);
  always_comb begin
    y = op == SUB ? a - b :
        op == AND ? a & b :
        op == OR  ? a | b :
        op == NOT ? ~a    : a + b;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter feeding one ALU, one operation in flight
// ALU_ARB_ZFLAG_EN: adds a registered result-is-zero flag on rsp_zero
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  state_t     state;
  logic       prio, id_r, gnt0, gnt1;
  logic [7:0] a_r, b_r, y;
  logic [2:0] op_r;
  // prio names the requester that wins when both are valid
  assign gnt0 = rst_n && state == IDLE && bus.req0_valid && (!bus.req1_valid || !prio);
  assign gnt1 = rst_n && state == IDLE && bus.req1_valid && (!bus.req0_valid || prio);
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  alu_core u_core (.a(a_r), .b(b_r), .op(op_r), .y(y));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= RR_INIT;
      id_r         <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= 1'b0;
`ifdef ALU_ARB_ZFLAG_EN
      bus.rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt0 || gnt1) begin
          a_r   <= gnt1 ? bus.req1_a  : bus.req0_a;
          b_r   <= gnt1 ? bus.req1_b  : bus.req0_b;
          op_r  <= gnt1 ? bus.req1_op : bus.req0_op;
          id_r  <= gnt1;
          state <= EXEC;
        end
        EXEC: begin
          bus.rsp_data  <= y;
          bus.rsp_id    <= id_r;
          bus.rsp_valid <= 1'b1;
`ifdef ALU_ARB_ZFLAG_EN
          bus.rsp_zero  <= y == 8'h00;
`endif
          state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          prio          <= ~bus.rsp_id;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus arbitration, backpressure and reset sequences
module tb_alu_arbiter;
  import alu_pkg::*;
  typedef struct {
    logic       id;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] d;
  } vec_t;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  vec_t tv[12];
  alu_arbiter_if bus ();
  alu_arbiter #(.RR_INIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
    #1;
    chk("ready_granted", id ? bus.req1_ready : bus.req0_ready, 8'd1);
    chk("ready_other", id ? bus.req0_ready : bus.req1_ready, 8'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("exec_rsp_valid", bus.rsp_valid, 8'd0);
  endtask
  task automatic expect_rsp(input logic [7:0] d, input logic id);
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, 8'd1);
    chk("rsp_data", bus.rsp_data, d);
    chk("rsp_id", bus.rsp_id, id);
`ifdef ALU_ARB_ZFLAG_EN
    chk("rsp_zero", bus.rsp_zero, d == 8'h00);
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_clear", bus.rsp_valid, 8'd0);
  endtask
  initial begin
    tv[0]  = '{1'b0, 8'h05, 8'h03, ADD,    8'h08};
    tv[1]  = '{1'b1, 8'h10, 8'h20, SUB,    8'hF0};
    tv[2]  = '{1'b0, 8'hF0, 8'h3C, AND,    8'h30};
    tv[3]  = '{1'b1, 8'hF0, 8'h0F, OR,     8'hFF};
    tv[4]  = '{1'b0, 8'h5A, 8'h00, NOT,    8'hA5};
    tv[5]  = '{1'b1, 8'h01, 8'hFF, 3'b110, 8'h00};
    tv[6]  = '{1'b0, 8'hFF, 8'h01, ADD,    8'h00};
    tv[7]  = '{1'b1, 8'h80, 8'h80, 3'b101, 8'h00};
    tv[8]  = '{1'b0, 8'h03, 8'h04, 3'b111, 8'h07};
    tv[9]  = '{1'b1, 8'h00, 8'h01, SUB,    8'hFF};
    tv[10] = '{1'b1, 8'h01, 8'h01, SUB,    8'h00};
    tv[11] = '{1'b0, 8'h02, 8'h01, SUB,    8'h01};
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_valid = 1'b1;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 8'd0);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_rsp_id", bus.rsp_id, 8'd0);
    chk("rst_ready0", bus.req0_ready, 8'd0);
    chk("rst_ready1", bus.req1_ready, 8'd0);
`ifdef ALU_ARB_ZFLAG_EN
    chk("rst_rsp_zero", bus.rsp_zero, 8'd0);
`endif
    // both requesters valid: req0 first, req1 next, then req0 again
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_a = 8'h10; bus.req0_b = 8'h20; bus.req0_op = SUB;
    bus.req1_a = 8'hF0; bus.req1_b = 8'h3C; bus.req1_op = AND;
    #1;
    chk("both_ready0", bus.req0_ready, 8'd1);
    chk("both_ready1", bus.req1_ready, 8'd0);
    @(negedge clk);
    bus.req0_a = 8'h07; bus.req0_b = 8'h01; bus.req0_op = ADD;
    chk("exec_ready0", bus.req0_ready, 8'd0);
    chk("exec_ready1", bus.req1_ready, 8'd0);
    chk("exec_rsp_valid", bus.rsp_valid, 8'd0);
    @(negedge clk);
    chk("both_rsp0_valid", bus.rsp_valid, 8'd1);
    chk("both_rsp0_data", bus.rsp_data, 8'hF0);
    chk("both_rsp0_id", bus.rsp_id, 8'd0);
    chk("resp_ready0", bus.req0_ready, 8'd0);
    chk("resp_ready1", bus.req1_ready, 8'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rr_ready1", bus.req1_ready, 8'd1);
    chk("rr_ready0", bus.req0_ready, 8'd0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    chk("exec2_rsp_valid", bus.rsp_valid, 8'd0);
    @(negedge clk);
    chk("both_rsp1_valid", bus.rsp_valid, 8'd1);
    chk("both_rsp1_data", bus.rsp_data, 8'h30);
    chk("both_rsp1_id", bus.rsp_id, 8'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("rr_back_ready0", bus.req0_ready, 8'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    expect_rsp(8'h08, 1'b0);
    for (int i = 0; i < 12; i++) begin
      issue(tv[i].id, tv[i].a, tv[i].b, tv[i].op);
      expect_rsp(tv[i].d, tv[i].id);
    end
    // response backpressure with a competing request pending
    issue(1'b0, 8'h33, 8'h11, SUB);
    @(negedge clk);
    bus.req1_a = 8'h01; bus.req1_b = 8'h01; bus.req1_op = ADD; bus.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_valid", bus.rsp_valid, 8'd1);
      chk("hold_data", bus.rsp_data, 8'h22);
      chk("hold_id", bus.rsp_id, 8'd0);
      chk("hold_ready0", bus.req0_ready, 8'd0);
      chk("hold_ready1", bus.req1_ready, 8'd0);
      @(negedge clk);
    end
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("hold_end_valid", bus.rsp_valid, 8'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("hold_done_valid", bus.rsp_valid, 8'd0);
    // reset while the operation is in EXEC
    issue(1'b1, 8'h44, 8'h11, ADD);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", bus.rsp_valid, 8'd0);
    chk("rst_exec_data", bus.rsp_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_stale_1", bus.rsp_valid, 8'd0);
    @(negedge clk);
    chk("no_stale_2", bus.rsp_valid, 8'd0);
    issue(1'b0, 8'h21, 8'h12, ADD);
    expect_rsp(8'h33, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
